// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the PDM transmitter and receiver.
package audio_pkg;

   localparam int              SAMPLE_W        = 8;
   localparam logic [7:0]      SILENCE         = 8'h80;
   localparam int              DEFAULT_CLK_DIV = 40;
   localparam int              DEFAULT_OSR     = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with a first-word fall-through head and registered occupancy.
module audio_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                 PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM playback: sample FIFO feeding a first-order sigma-delta modulator.
module pdm_audio_tx
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int OSR        = DEFAULT_OSR,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [SAMPLE_W-1:0]           dataIn,
   input  logic                          dataValid,
   output logic                          dataAccept,
   output logic                          AUDIO_PWM,
   output logic                          AUDIO_SD,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

   localparam int               DIV_W    = $clog2(CLK_DIV);
   localparam int               BIT_W    = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

   state_t              state;
   state_t              next_state;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [SAMPLE_W-1:0] acc;
   logic [SAMPLE_W-1:0] cur_sample;
   logic [SAMPLE_W:0]   sum;
   logic                tick;
   logic                load;
   logic                fifo_full;
   logic                fifo_empty;
   logic [SAMPLE_W-1:0] fifo_head;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (dataValid),
      .pop   (load),
      .din   (dataIn),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifoCount)
   );

   assign dataAccept = !fifo_full;
   assign tick       = (state == RUN) && (div_cnt == DIV_LAST);
   assign sum        = {1'b0, acc} + {1'b0, cur_sample};

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               next_state = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (!enable) begin
               next_state = IDLE;
            end else if (tick && (bit_cnt == BIT_LAST)) begin
               load = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         acc        <= '0;
         cur_sample <= SILENCE;
         AUDIO_PWM  <= 1'b0;
         AUDIO_SD   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state    <= next_state;
         AUDIO_SD <= (next_state == RUN);
         underrun <= load && fifo_empty;

         if ((state == RUN) && (next_state == RUN)) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
               bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
               acc       <= sum[SAMPLE_W-1:0];
               AUDIO_PWM <= sum[SAMPLE_W];
            end
         end else begin
            // Idle, entering RUN or leaving it: modulator restarts from a clean phase.
            div_cnt   <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            AUDIO_PWM <= 1'b0;
         end

         // The last tick of a sample still modulates the old value; the new one takes over after.
         if (load) begin
            cur_sample <= fifo_empty ? SILENCE : fifo_head;
         end
      end
   end

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Self-checking bench: queue/arithmetic reference model compared every clock, plus scenario checks.
module tb_pdm_audio_tx;

   localparam int CLK_DIV = 40;
   localparam int OSR     = 64;
   localparam int DEPTH   = 16;
   localparam int PERIOD  = CLK_DIV * OSR;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] dataIn;
   logic       dataValid;
   logic       dataAccept;
   logic       AUDIO_PWM;
   logic       AUDIO_SD;
   logic       underrun;
   logic [4:0] fifoCount;

   pdm_audio_tx #(
      .CLK_DIV    (CLK_DIV),
      .OSR        (OSR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .dataIn     (dataIn),
      .dataValid  (dataValid),
      .dataAccept (dataAccept),
      .AUDIO_PWM  (AUDIO_PWM),
      .AUDIO_SD   (AUDIO_SD),
      .underrun   (underrun),
      .fifoCount  (fifoCount)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Reference model: time measured in edges since the enable edge, FIFO as a queue.
   logic [7:0] m_q[$];
   int         m_t     = 0;
   bit         m_run   = 0;
   int         m_acc   = 0;
   int         m_cur   = 8'h80;
   bit         m_pwm   = 0;
   bit         m_under = 0;
   bit         m_tick  = 0;

   int         obs_ones  = 0;
   int         exp_ones  = 0;
   int         obs_under = 0;
   bit         obs_bits[$];

   task automatic model_edge();
      int pre;
      bit load;
      int sum;
      pre     = m_q.size();
      load    = 0;
      m_under = 0;
      m_tick  = 0;
      if (reset) begin
         m_q.delete();
         m_run = 0;
         m_t   = 0;
         m_acc = 0;
         m_cur = 8'h80;
         m_pwm = 0;
         return;
      end
      if (!m_run) begin
         if (enable) begin
            m_run = 1;
            m_t   = 0;
            load  = 1;
         end
      end else if (!enable) begin
         m_run = 0;
         m_acc = 0;
         m_pwm = 0;
      end else begin
         m_t++;
         if (m_t % CLK_DIV == 0) begin
            m_tick = 1;
            sum    = m_acc + m_cur;
            m_pwm  = (sum >= 256);
            m_acc  = sum % 256;
            if (m_t % PERIOD == 0) load = 1;
         end
      end
      if (load) begin
         if (pre > 0) begin
            m_cur = m_q.pop_front();
         end else begin
            m_cur   = 8'h80;
            m_under = 1;
         end
      end
      if (dataValid && pre < DEPTH) m_q.push_back(dataIn);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_edge();
      check("pwm", AUDIO_PWM, m_pwm);
      check("sd", AUDIO_SD, m_run);
      check("underrun", underrun, m_under);
      check("count", fifoCount, m_q.size());
      check("accept", dataAccept, m_q.size() < DEPTH);
      if (m_tick) begin
         obs_ones += AUDIO_PWM;
         exp_ones += m_pwm;
         obs_bits.push_back(AUDIO_PWM);
      end
      if (underrun === 1'b1) obs_under++;
   endtask

   task automatic clear_obs();
      obs_ones  = 0;
      exp_ones  = 0;
      obs_under = 0;
      obs_bits.delete();
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      dataValid = 1'b0;
      dataIn    = 8'h00;
      cycle();
      cycle();
      check("rst_pwm", AUDIO_PWM, 0);
      check("rst_sd", AUDIO_SD, 0);
      check("rst_underrun", underrun, 0);
      check("rst_count", fifoCount, 0);
      check("rst_accept", dataAccept, 1);
      reset = 1'b0;
      cycle();

      // Silence sample: alternating bits, then underrun at the second load.
      dataValid = 1'b1;
      dataIn    = 8'h80;
      cycle();
      dataValid = 1'b0;
      check("pre_sd", AUDIO_SD, 0);
      enable = 1'b1;
      cycle();
      check("sd_rise", AUDIO_SD, 1);
      clear_obs();
      for (int i = 0; i < PERIOD - 1; i++) cycle();
      check("under_early", obs_under, 0);
      cycle();
      check("under_2nd_load", underrun, 1);
      check("ones_80", obs_ones, 32);
      check("bits_seen", obs_bits.size(), OSR);
      if (obs_bits.size() >= 2) begin
         check("bit0", obs_bits[0], 0);
         check("bit1", obs_bits[1], 1);
      end
      cycle();
      check("under_one_cycle", underrun, 0);
      clear_obs();
      for (int i = 0; i < PERIOD - 1; i++) cycle();
      check("ones_80_cont", obs_ones, 32);

      // Reset mid-RUN with five samples queued.
      for (int i = 0; i < 5; i++) begin
         dataValid = 1'b1;
         dataIn    = 8'($urandom);
         cycle();
      end
      dataValid = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      check("queued5", fifoCount, 5);
      reset  = 1'b1;
      enable = 1'b0;
      cycle();
      check("rst_run_count", fifoCount, 0);
      check("rst_run_sd", AUDIO_SD, 0);
      check("rst_run_pwm", AUDIO_PWM, 0);
      check("rst_run_accept", dataAccept, 1);
      reset = 1'b0;
      cycle();

      // 0x00 then 0xFF.
      dataValid = 1'b1;
      dataIn    = 8'h00;
      cycle();
      dataIn = 8'hFF;
      cycle();
      dataValid = 1'b0;
      enable    = 1'b1;
      cycle();
      clear_obs();
      for (int i = 0; i < PERIOD; i++) cycle();
      check("ones_00", obs_ones, 0);
      obs_ones = 0;
      exp_ones = 0;
      for (int i = 0; i < PERIOD - 1; i++) cycle();
      check("under_128", obs_under, 0);
      cycle();
      check("ones_ff", obs_ones, exp_ones);
      enable = 1'b0;
      cycle();

      // Fill with dataValid held while idle; the 17th push is dropped.
      dataValid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         dataIn = 8'($urandom);
         cycle();
      end
      check("fill_count", fifoCount, 16);
      check("fill_accept", dataAccept, 0);
      dataIn = 8'($urandom);
      cycle();
      check("reject17_count", fifoCount, 16);
      dataIn = 8'($urandom);
      enable = 1'b1;
      cycle();
      check("full_pushpop", fifoCount, 15);
      dataValid = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
         obs_ones = 0;
         exp_ones = 0;
         for (int i = 0; i < PERIOD; i++) cycle();
         check("drain_ones", obs_ones, exp_ones);
      end
      check("drain_underrun", underrun, 1);

      // Push lands on the same edge as a load that finds the FIFO empty.
      for (int i = 0; i < PERIOD && ((m_t + 1) % PERIOD) != 0; i++) cycle();
      dataValid = 1'b1;
      dataIn    = 8'($urandom_range(0, 96));
      cycle();
      dataValid = 1'b0;
      check("coinc_underrun", underrun, 1);
      check("coinc_count", fifoCount, 1);
      obs_ones = 0;
      exp_ones = 0;
      for (int i = 0; i < PERIOD; i++) cycle();
      check("coinc_silence", obs_ones, 32);
      check("coinc_popped", fifoCount, 0);
      obs_ones = 0;
      exp_ones = 0;
      for (int i = 0; i < PERIOD; i++) cycle();
      check("coinc_plays", obs_ones, exp_ones);

      // Random soak: sporadic enable toggles and bursty pushes.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) enable = !enable;
         dataValid = ($urandom_range(0, 3) == 0);
         dataIn    = 8'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_audio_tx.md
# pdm_audio_tx

Playback end of the audio path and the counterpart of the microphone PDM receiver. Accepts 8-bit unsigned PCM samples on a valid/ready handshake, buffers them in a small FIFO, and re-modulates each sample into a 1-bit pulse-density stream using a first-order sigma-delta modulator. Drives the board's mono audio amplifier (AUDIO_PWM, AUDIO_SD).

## Interface
- CLK_DIV, 40: clk cycles per output bit; 100 MHz / 40 = 2.5 MHz bit rate. Must be ≥ 2.
- OSR, 64: output bits per sample; sample period = CLK_DIV·OSR = 2560 clk.
- FIFO_DEPTH, 16: sample FIFO entries; power of 2, ≥ 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = play, 0 = idle / amplifier shutdown.
- dataIn  in  8  unsigned offset-binary sample; 0x80 = silence.
- dataValid  in  1  dataIn is valid this cycle.
- dataAccept  out  1  FIFO not full; a push occurs when dataValid && dataAccept.
- AUDIO_PWM  out  1  pulse-density output bit, registered.
- AUDIO_SD  out  1  amplifier enable, registered; 1 in RUN.
- underrun  out  1  one-cycle pulse when a sample load finds the FIFO empty.
- fifoCount  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- **States**
  - IDLE:
    - divider, bit counter and accumulator are held at 0;
    - AUDIO_PWM = 0 and AUDIO_SD = 0;
    - the FIFO still accepts pushes.
  - IDLE→RUN when enable = 1. On the transition cycle, load the current sample (see Sample load).
  - RUN→IDLE when enable = 0, immediately, mid-sample. Counters and accumulator are cleared. FIFO contents are kept; the sample in progress is discarded.
- **Divider**
  - divCnt counts 0..CLK_DIV-1 in RUN.
  - tick = (divCnt == CLK_DIV-1).
- **Bit counter**
  - bitCnt counts 0..OSR-1.
  - Advances on tick and wraps to 0.
- **Modulator**
  - 9-bit sum = {1'b0, acc[7:0]} + {1'b0, curSample}.
  - On tick: acc ← sum[7:0] and AUDIO_PWM ← sum[8].
  - Ones density is exactly curSample/256.
- **Sample load**
  - Occurs on the IDLE→RUN transition, and on a tick where bitCnt == OSR-1.
  - If the FIFO is non-empty: pop it and curSample ← head.
  - If the FIFO is empty: curSample ← 0x80 and pulse underrun.
  - acc is not reset at a sample load.
- **FIFO**
  - Synchronous, first-word fall-through head.
  - dataAccept = !full, computed from registered occupancy.
  - Push and pop in the same cycle:
    - when full, the push is rejected (dataAccept = 0) and the pop proceeds;
    - when empty, the pop sees empty (underrun, 0x80 loaded) and the push is stored.
  - A push while full is ignored, with no corruption.

## Timing
- **Reset values:** state = IDLE, AUDIO_PWM = 0, AUDIO_SD = 0, underrun = 0, fifoCount = 0, dataAccept = 1, acc = 0, curSample = 0x80, counters = 0.
- **Enable latency:** enable = 1 sampled at edge N gives AUDIO_SD = 1 after edge N. The first tick is at edge N+CLK_DIV, and AUDIO_PWM shows its first bit after that edge.
- AUDIO_PWM changes only on tick edges, so each bit is held exactly CLK_DIV cycles.
- **Push visibility:** fifoCount and dataAccept update on the edge after the push.
- underrun is high for exactly one clk cycle, coincident with the failed load.
- reset overrides everything, including mid-sample and with a full FIFO. The FIFO is emptied.

## Structure
- Package audio_pkg holds:
  - SAMPLE_W = 8;
  - SILENCE = 8'h80;
  - state enum {IDLE, RUN};
  - default CLK_DIV / OSR.
  The PDM receiver shares SAMPLE_W and SILENCE.
- Sub-module audio_sample_fifo contains storage, pointers, count, full/empty and the head output, parameterised by depth and width.
- The top level contains the FSM, divider, bit counter and modulator.

## Test plan
- **Reset mid-RUN with 5 samples queued:** next cycle shows fifoCount = 0, AUDIO_SD = 0, AUDIO_PWM = 0, dataAccept = 1.
- **Push 0x80, enable:**
  - AUDIO_SD rises one cycle after enable;
  - bits per 40-cycle slot are 0,1,0,1…;
  - 32 ones in the 64-bit sample;
  - underrun pulses at the second load, then 0x80 continues.
- **Push 0x00 then 0xFF:**
  - first 64 bits are all 0;
  - next 64 bits contain 63 or 64 ones, with the exact count checked against the reference-model accumulator;
  - no underrun during these 128 bits.
- **Hold dataValid = 1 with enable = 0:**
  - 16 pushes accepted;
  - dataAccept = 0 after the 16th;
  - the 17th sample is not stored;
  - after enable, samples are drained in order and checked against the accumulator model.
- **Full FIFO, push and pop in the same cycle:** fifoCount goes 16→15, the push is rejected, and the order is preserved.
- **Empty FIFO, push and load in the same cycle:** underrun pulses, curSample = 0x80, fifoCount = 1, and the pushed sample plays in the next sample period.
